// File: rtl/debounced_priority_encoder.sv
// Switch synchroniser, debouncer and priority encoder with registered binary/BCD result,
// change strobe and saturating change counter.
module debounced_priority_encoder #(
   parameter int  NUM_SW          = 18,
   parameter int  DEBOUNCE_CYCLES = 500000,
   localparam int IDX_W           = $clog2(NUM_SW)
) (
   input  logic              CLOCK_50_I,
   input  logic              RESET_I,
   input  logic [NUM_SW-1:0] SWITCH_I,
   input  logic              LSB_PRIORITY_I,
   input  logic              HOLD_I,
   output logic              VALID_O,
   output logic [IDX_W-1:0]  INDEX_O,
   output logic [3:0]        BCD_TENS_O,
   output logic [3:0]        BCD_ONES_O,
   output logic              CHANGE_O,
   output logic [7:0]        CHANGE_COUNT_O
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0] sync1_q, sync2_q, cand_q, deb_q, deb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              valid_q, change_q;
   logic [IDX_W-1:0]  index_q;
   logic [3:0]        tens_q, ones_q;
   logic [7:0]        count_q;

   logic              valid_d, change_d;
   logic [IDX_W-1:0]  index_d;
   logic [3:0]        tens_d, ones_d;
   logic [7:0]        count_d;

   logic              enc_v;
   logic [IDX_W-1:0]  enc_idx;
   logic [7:0]        enc_idx8;

   // A candidate only counts while it differs from the accepted vector and holds still.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q != cand_q || sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Scan order decides the winner: the last set bit visited is kept.
   always_comb begin
      enc_v   = 1'b0;
      enc_idx = '0;
      if (LSB_PRIORITY_I) begin
         for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (deb_q[i]) begin
               enc_v   = 1'b1;
               enc_idx = IDX_W'(i);
            end
         end
      end else begin
         for (int i = 0; i < NUM_SW; i++) begin
            if (deb_q[i]) begin
               enc_v   = 1'b1;
               enc_idx = IDX_W'(i);
            end
         end
      end
   end

   assign enc_idx8 = 8'(enc_idx);

   always_comb begin
      valid_d  = valid_q;
      index_d  = index_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      change_d = 1'b0;
      count_d  = count_q;
      if (!HOLD_I) begin
         valid_d  = enc_v;
         index_d  = enc_idx;
         tens_d   = enc_v ? 4'(enc_idx8 / 8'd10) : 4'hF;
         ones_d   = enc_v ? 4'(enc_idx8 % 8'd10) : 4'hF;
         change_d = ({enc_v, enc_idx} != {valid_q, index_q});
         if (change_d && count_q != 8'hFF) count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge CLOCK_50_I) begin
      if (RESET_I) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         deb_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         index_q  <= '0;
         tens_q   <= 4'hF;
         ones_q   <= 4'hF;
         change_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         sync1_q  <= SWITCH_I;
         sync2_q  <= sync1_q;
         cand_q   <= sync2_q;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         index_q  <= index_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         change_q <= change_d;
         count_q  <= count_d;
      end
   end

   assign VALID_O        = valid_q;
   assign INDEX_O        = index_q;
   assign BCD_TENS_O     = tens_q;
   assign BCD_ONES_O     = ones_q;
   assign CHANGE_O       = change_q;
   assign CHANGE_COUNT_O = count_q;

endmodule

// File: tb/tb_debounced_priority_encoder.sv
// Randomised and directed bench for debounced_priority_encoder against a run-length reference model.
module tb_debounced_priority_encoder;

   localparam int NSW = 18;
   localparam int DB  = 4;
   localparam int IW  = $clog2(NSW);

   logic           clk = 1'b0;
   logic           rst, lsb, hold;
   logic [NSW-1:0] sw;
   logic           valid_o, change_o;
   logic [IW-1:0]  index_o;
   logic [3:0]     tens_o, ones_o;
   logic [7:0]     count_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: sampled switch delay line, current run of identical samples, accepted vector.
   logic [NSW-1:0] m_s1, m_s2, m_run_val, m_deb;
   int             m_run_len;
   logic           m_v, m_chg;
   int             m_idx, m_tens, m_ones, m_cnt;

   debounced_priority_encoder #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DB)) dut (
      .CLOCK_50_I    (clk),
      .RESET_I       (rst),
      .SWITCH_I      (sw),
      .LSB_PRIORITY_I(lsb),
      .HOLD_I        (hold),
      .VALID_O       (valid_o),
      .INDEX_O       (index_o),
      .BCD_TENS_O    (tens_o),
      .BCD_ONES_O    (ones_o),
      .CHANGE_O      (change_o),
      .CHANGE_COUNT_O(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner index, or -1 when nothing is set.
   function automatic int winner(input logic [NSW-1:0] v, input logic lsb_mode);
      int w = -1;
      for (int i = 0; i < NSW; i++)
         if (v[i] && (w < 0 || !lsb_mode)) w = i;
      return w;
   endfunction

   task automatic model_edge();
      int w;
      logic [NSW-1:0] s;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = 1; m_deb = '0;
         m_v = 0; m_idx = 0; m_tens = 15; m_ones = 15; m_chg = 0; m_cnt = 0;
         return;
      end
      if (hold) begin
         m_chg = 0;
      end else begin
         w = winner(m_deb, lsb);
         m_chg = ((w >= 0) != m_v) || ((w >= 0) && w != m_idx);
         if (m_chg && m_cnt < 255) m_cnt++;
         m_v    = (w >= 0);
         m_idx  = m_v ? w : 0;
         m_tens = m_v ? w / 10 : 15;
         m_ones = m_v ? w % 10 : 15;
      end
      // A new vector is taken once it has been seen DB+1 times in a row at the sync output.
      s = m_s2;
      if (s == m_run_val) begin
         if (m_run_len < 1000) m_run_len++;
      end else begin
         m_run_val = s;
         m_run_len = 1;
      end
      if (m_run_len == DB + 1 && s != m_deb) m_deb = s;
      m_s2 = m_s1;
      m_s1 = sw;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("valid",  32'(valid_o),  32'(m_v));
      chk("index",  32'(index_o),  32'(m_idx));
      chk("tens",   32'(tens_o),   32'(m_tens));
      chk("ones",   32'(ones_o),   32'(m_ones));
      chk("change", 32'(change_o), 32'(m_chg));
      chk("count",  32'(count_o),  32'(m_cnt));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst = 1; lsb = 0; hold = 0; sw = '0;
      run(2);
      rst = 0;
      run(20);
      chk("rst_count", 32'(count_o), 32'd0);

      // Latency: result appears on the 8th edge counting the sampling edge.
      sw = NSW'((1 << 17) | (1 << 3));
      run(7);
      chk("lat_early", 32'(valid_o), 32'd0);
      cyc();
      chk("lat_idx", 32'(index_o), 32'd17);
      chk("lat_chg", 32'(change_o), 32'd1);
      run(3);
      lsb = 1;
      cyc();
      chk("mode_idx", 32'(index_o), 32'd3);
      chk("mode_cnt", 32'(count_o), 32'd2);

      // Short glitches on bit 10 are never accepted.
      for (int r = 0; r < 5; r++) begin
         sw[10] = 1'b1; run(3);
         sw[10] = 1'b0; run(3);
      end
      chk("glitch_cnt", 32'(count_o), 32'd2);

      hold = 1; sw = NSW'(1 << 5);
      run(20);
      hold = 0;
      cyc();
      chk("hold_idx", 32'(index_o), 32'd5);
      chk("hold_chg", 32'(change_o), 32'd1);

      for (int p = 0; p < 300; p++) begin
         sw = (p % 2 == 0) ? NSW'(1 << 1) : NSW'(1 << 2);
         run(10);
      end
      chk("sat_cnt", 32'(count_o), 32'd255);

      sw = NSW'(1 << 9);
      run(2);
      rst = 1;
      cyc();
      chk("rst_mid_tens", 32'(tens_o), 32'd15);
      rst = 0;
      run(10);
      chk("rel_idx", 32'(index_o), 32'd9);
      chk("rel_cnt", 32'(count_o), 32'd1);

      for (int it = 0; it < 1200; it++) begin
         case ($urandom_range(0, 3))
            0: sw = NSW'($urandom);
            1: sw = NSW'(1 << $urandom_range(0, NSW - 1));
            2: sw = sw ^ NSW'(1 << $urandom_range(0, NSW - 1));
            default: sw = '0;
         endcase
         hold = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) lsb = ~lsb;
         rst  = ($urandom_range(0, 49) == 0);
         run($urandom_range(1, 9));
         rst = 0;
      end
      hold = 0;
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/debounced_priority_encoder.md
# debounced_priority_encoder

Parametrised, registered successor to the switch priority encoder: synchronises and debounces an N-bit switch vector, selects the highest- or lowest-index active switch, and presents it as a binary index and two BCD digits for the seven-segment converters. It adds selectable priority direction, a display hold, a change strobe and a saturating change counter. It sits between the board switch inputs and the hex-to-seven-segment units in the top level.

## Interface
- NUM_SW, 18, number of switch inputs; legal range 2..100, so the index fits two BCD digits.
- DEBOUNCE_CYCLES, 500000, cycles a new switch vector must stay stable before acceptance; minimum 2.
- IDX_W, $clog2(NUM_SW), width of INDEX_O; derived, not overridden.
- CLOCK_50_I  in  1  system clock; all logic on rising edge.
- RESET_I  in  1  reset, synchronous, active-high.
- SWITCH_I  in  NUM_SW  raw asynchronous switch vector.
- LSB_PRIORITY_I  in  1  0: highest set index wins; 1: lowest set index wins. Synchronous to CLOCK_50_I.
- HOLD_I  in  1  1: freeze all result outputs. Synchronous to CLOCK_50_I.
- VALID_O  out  1  at least one debounced switch is set.
- INDEX_O  out  IDX_W  winning switch index; 0 when !VALID_O.
- BCD_TENS_O  out  4  INDEX_O / 10; 4'hF when !VALID_O.
- BCD_ONES_O  out  4  INDEX_O % 10; 4'hF when !VALID_O.
- CHANGE_O  out  1  one-cycle pulse when the {VALID_O, INDEX_O} pair takes a new value.
- CHANGE_COUNT_O  out  8  number of CHANGE_O pulses since reset; saturates at 255.

## Operation
- Sync stage: two flops, sync1 then sync2, on SWITCH_I.
- Debounce state: a candidate register cand is loaded from sync2 every cycle. There is also a stability counter cnt and an accepted vector deb.
  - If sync2 != cand or sync2 == deb, then cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then deb <= sync2 and cnt <= 0.
  - Else cnt <= cnt + 1.
- Encode is combinational on deb and LSB_PRIORITY_I.
  - Priority scan gives idx and v.
  - BCD uses the division/modulo by 10 rules above, with 4'hF/4'hF when v = 0.
- Output registers:
  - If HOLD_I = 1: all outputs keep their value, CHANGE_O = 0 and the counter is unchanged.
  - Otherwise, VALID_O, INDEX_O and both BCD outputs load the encode result.
  - CHANGE_O <= ({v, idx} != {VALID_O, INDEX_O}).
  - CHANGE_COUNT_O increments on that same condition, unless it is already 255.
- LSB_PRIORITY_I is not debounced. A mode flip re-encodes the current deb directly.
- Reset values: sync1, sync2, cand and deb = 0; cnt = 0; VALID_O = 0; INDEX_O = 0; BCD_TENS_O = BCD_ONES_O = 4'hF; CHANGE_O = 0; CHANGE_COUNT_O = 0.

## Timing
- Switch to output latency: SWITCH_I is stable from sampling edge k.
  - deb updates at edge k+2+DEBOUNCE_CYCLES.
  - Outputs and CHANGE_O update at edge k+3+DEBOUNCE_CYCLES.
- Glitches: any vector change shorter than DEBOUNCE_CYCLES+1 cycles at sync2 is never accepted.
  - A bounce back to deb clears cnt.
  - A bounce to a third value restarts the count.
- Mode or HOLD_I release: outputs reflect the current deb/mode at the first edge where HOLD_I = 0. Latency is one cycle.
- Simultaneous HOLD_I = 1 and deb acceptance: deb still updates, but the outputs do not. The change appears one cycle after release.
- Same-result cases give no CHANGE_O pulse:
  - the vector changes but the winner does not (e.g. a lower bit added in MSB mode);
  - the mode flips with a single bit set.
- Reset during debounce or hold: every register returns to its reset value on that edge, and any pending vector is discarded.
  - Switches already on at reset release are debounced afresh.
  - They produce one CHANGE_O pulse and CHANGE_COUNT_O = 1.
- There is no back-pressure. CHANGE_O is never high on two consecutive cycles without an intervening result change.

## Test plan
All scenarios use NUM_SW = 18 and DEBOUNCE_CYCLES = 4.
- Reset with SWITCH_I = 0 and hold for 20 cycles -> VALID_O = 0, INDEX_O = 0, BCD F/F, CHANGE_O never high, CHANGE_COUNT_O = 0.
- SWITCH_I = bits 17 and 3, LSB_PRIORITY_I = 0 -> exactly 7 edges later INDEX_O = 17, BCD 1/7, one CHANGE_O pulse, count = 1.
  - Then set LSB_PRIORITY_I = 1 -> next edge INDEX_O = 3, BCD 0/3, pulse, count = 2.
- Bit 10 raised for 3 cycles then dropped, repeated 5 times -> outputs, CHANGE_O and count unchanged throughout.
- HOLD_I = 1, SWITCH_I changed to bit 5 only, wait 20 cycles -> outputs unchanged and no pulse.
  - Drop HOLD_I -> next edge INDEX_O = 5, BCD 0/5, one pulse.
- Alternate SWITCH_I between bit 1 and bit 2 every 10 cycles for 300 periods -> CHANGE_COUNT_O stops at 255, and CHANGE_O still pulses at each change.
- SWITCH_I = bit 9 with RESET_I asserted 2 cycles after the change -> all reset values.
  - Release reset with bit 9 still set -> INDEX_O = 9 and BCD 0/9 after the full latency, count = 1.
